// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a rectangular sprite from a 4-bit palette ROM into an
// 800x480 framebuffer, one pixel per clock. Palette index 15 is transparent and
// pixels falling outside the screen are clipped, but every pixel still costs
// exactly one cycle so blit duration depends only on the sprite size.
`timescale 1ns/1ps
module sprite_blitter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] pos_x,
   input  logic [10:0] pos_y,
   input  logic [15:0] spr_base,
   input  logic [7:0]  spr_w,
   input  logic [7:0]  spr_h,
   output logic        ready,
   output logic        done,
   output logic [15:0] spr_addr,
   input  logic [3:0]  spr_data,
   output logic [18:0] fb_addr,
   output logic [3:0]  fb_data,
   output logic        fb_we
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;

   // latched blit operands
   logic [11:0] px_r;
   logic [10:0] py_r;
   logic [7:0]  w_r;
   logic [7:0]  h_r;

   // current pixel being read from the sprite ROM
   logic [7:0]  row_r;
   logic [7:0]  col_r;
   logic [15:0] spr_addr_r;

   // write stage: pixel read last cycle, written while its ROM data is valid
   logic        pend_r;
   logic        inb_r;
   logic [18:0] fb_addr_r;

   logic        ready_r;
   logic        done_r;

   logic        accept_s;
   logic        last_s;
   logic        empty_s;
   logic [12:0] sx_s;
   logic [12:0] sy_s;
   logic        inb_s;
   logic [18:0] lin_s;

   assign accept_s = (state_r == IDLE) && start;
   assign empty_s  = (spr_w == 8'd0) || (spr_h == 8'd0);
   assign last_s   = (col_r == (w_r - 8'd1)) && (row_r == (h_r - 8'd1));

   // Screen coordinates are widened to 13 bits signed so pos + offset never wraps.
   assign sx_s  = {px_r[11], px_r} + {5'd0, col_r};
   assign sy_s  = {{2{py_r[10]}}, py_r} + {5'd0, row_r};
   assign inb_s = !sx_s[12] && (sx_s <= 13'd799) && !sy_s[12] && (sy_s <= 13'd479);
   assign lin_s = ({10'd0, sy_s[8:0]} * 19'd800) + {9'd0, sx_s[9:0]};

   // Next-state logic for the blit sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (empty_s) begin
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN:   state_s = DONE;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register, registered status flags, operand latches and pixel counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         ready_r    <= 1'b1;
         done_r     <= 1'b0;
         px_r       <= 12'd0;
         py_r       <= 11'd0;
         w_r        <= 8'd0;
         h_r        <= 8'd0;
         row_r      <= 8'd0;
         col_r      <= 8'd0;
         spr_addr_r <= 16'd0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         done_r  <= (state_s == DONE);
         if (accept_s) begin
            px_r       <= pos_x;
            py_r       <= pos_y;
            w_r        <= spr_w;
            h_r        <= spr_h;
            row_r      <= 8'd0;
            col_r      <= 8'd0;
            spr_addr_r <= spr_base;
         end else if ((state_r == RUN) && !last_s) begin
            // row*w+col is just the linear pixel index, so the ROM address increments
            spr_addr_r <= spr_addr_r + 16'd1;
            if (col_r == (w_r - 8'd1)) begin
               col_r <= 8'd0;
               row_r <= row_r + 8'd1;
            end else begin
               col_r <= col_r + 8'd1;
            end
         end else begin
            spr_addr_r <= spr_addr_r;
         end
      end
   end

   // Write stage: capture the framebuffer target of the pixel read this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r    <= 1'b0;
         inb_r     <= 1'b0;
         fb_addr_r <= 19'd0;
      end else begin
         pend_r <= (state_r == RUN);
         if (state_r == RUN) begin
            inb_r     <= inb_s;
            fb_addr_r <= inb_s ? lin_s : 19'd0;
         end else begin
            inb_r     <= 1'b0;
            fb_addr_r <= fb_addr_r;
         end
      end
   end

   // ROM data arrives in the write cycle, so data and enable follow it directly.
   assign fb_we    = pend_r && inb_r && (spr_data != 4'd15);
   assign fb_data  = pend_r ? spr_data : 4'd0;
   assign fb_addr  = fb_addr_r;
   assign spr_addr = spr_addr_r;
   assign ready    = ready_r;
   assign done     = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed corner cases plus randomized
// blits compared against a per-pixel reference model of the expected writes.
`timescale 1ns/1ps
module tb_sprite_blitter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] pos_x = 12'd0;
   logic [10:0] pos_y = 11'd0;
   logic [15:0] spr_base = 16'd0;
   logic [7:0]  spr_w = 8'd0;
   logic [7:0]  spr_h = 8'd0;
   logic        ready;
   logic        done;
   logic [15:0] spr_addr;
   logic [3:0]  spr_data = 4'd0;
   logic [18:0] fb_addr;
   logic [3:0]  fb_data;
   logic        fb_we;

   logic [3:0]  rom [0:65535];

   int checks = 0;
   int errors = 0;

   sprite_blitter dut (
      .clk(clk), .rst(rst), .start(start),
      .pos_x(pos_x), .pos_y(pos_y), .spr_base(spr_base),
      .spr_w(spr_w), .spr_h(spr_h),
      .ready(ready), .done(done), .spr_addr(spr_addr), .spr_data(spr_data),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
   );

   always #5 clk = ~clk;

   // synchronous sprite ROM: data valid the cycle after the address
   always @(posedge clk) spr_data <= rom[spr_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One blit, compared against a model derived directly from the sprite rules.
   task automatic do_blit(input int px, input int py, input int base,
                          input int w, input int h, input bit mid);
      int ea[$]; int ed[$]; int ga[$]; int gd[$];
      int n, exp_done, done_k, done_n, a, sx, sy;
      n = w * h;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            a  = (base + r * w + c) & 32'hFFFF;
            sx = px + c;
            sy = py + r;
            if (rom[a] != 4'd15 && sx >= 0 && sx <= 799 && sy >= 0 && sy <= 479) begin
               ea.push_back(sy * 800 + sx);
               ed.push_back(int'(rom[a]));
            end
         end
      end
      exp_done = (n == 0) ? 1 : n + 2;
      @(negedge clk);
      check("ready_idle", ready, 1);
      pos_x = px[11:0]; pos_y = py[10:0]; spr_base = base[15:0];
      spr_w = w[7:0];   spr_h = h[7:0];   start = 1'b1;
      done_k = 0; done_n = 0;
      for (int k = 1; k <= exp_done + 1; k++) begin
         @(negedge clk);
         if (k == 1) check("ready_busy", ready, 0);
         if (fb_we) begin
            ga.push_back(int'(fb_addr));
            gd.push_back(int'(fb_data));
         end
         if (done) begin
            done_n++;
            done_k = k;
         end
         if (k == exp_done + 1) begin
            check("ready_after_done", ready, 1);
            check("done_pulse_width", done, 0);
         end
         start = mid && (k == 3);
         if (start) begin
            pos_x = 12'($urandom); pos_y = 11'($urandom);
            spr_base = 16'($urandom); spr_w = 8'd3; spr_h = 8'd3;
         end
      end
      start = 1'b0;
      check("write_count", ga.size(), ea.size());
      for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
         check("write_addr", ga[i], ea[i]);
         check("write_data", gd[i], ed[i]);
      end
      check("done_cycle", done_k, exp_done);
      check("done_count", done_n, 1);
   endtask

   task automatic rand_pos(output int px, output int py);
      logic signed [11:0] tx;
      logic signed [10:0] ty;
      tx = 12'($urandom); ty = 11'($urandom);
      case ($urandom_range(0, 3))
         0: begin px = $urandom_range(0, 799); py = $urandom_range(0, 479); end
         1: begin px = int'($urandom_range(0, 20)) - 15; py = int'($urandom_range(0, 20)) - 15; end
         2: begin px = $urandom_range(785, 805); py = $urandom_range(465, 485); end
         default: begin px = int'(tx); py = int'(ty); end
      endcase
   endtask

   initial begin
      int px, py, base, w, h, we_seen, done_seen;
      for (int i = 0; i < 65536; i++) rom[i] = 4'd0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_spr_addr", spr_addr, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_data", fb_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // 2x2 at origin with one transparent pixel
      rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd15; rom[3] = 4'd3;
      do_blit(0, 0, 0, 2, 2, 1'b0);

      // 4x1 at the bottom-right corner, two pixels clipped
      for (int i = 0; i < 4; i++) rom[16'h0100 + i] = 4'd5;
      do_blit(798, 479, 16'h0100, 4, 1, 1'b0);

      // left clip
      rom[16'h0200] = 4'd7; rom[16'h0201] = 4'd9;
      do_blit(-1, 0, 16'h0200, 2, 1, 1'b0);

      // empty sprite
      do_blit(10, 10, 0, 0, 10, 1'b0);

      // 8x8 with an ignored second start
      for (int i = 0; i < 64; i++) rom[16'h1000 + i] = 4'($urandom_range(0, 15));
      do_blit(100, 50, 16'h1000, 8, 8, 1'b1);

      // reset in RUN cycle 3 of a 4x4 blit
      for (int i = 0; i < 16; i++) rom[16'h2000 + i] = 4'd1;
      @(negedge clk);
      pos_x = 12'd10; pos_y = 11'd10; spr_base = 16'h2000;
      spr_w = 8'd4; spr_h = 8'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_we", fb_we, 1);
      rst = 1'b1;
      #1;
      check("abort_fb_we", fb_we, 0);
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      we_seen = 0; done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (fb_we) we_seen++;
         if (done) done_seen++;
      end
      check("abort_no_writes", we_seen, 0);
      check("abort_no_done", done_seen, 0);
      rom[16'h3000] = 4'd6;
      do_blit(5, 6, 16'h3000, 1, 1, 1'b0);

      // randomized blits
      for (int t = 0; t < 30; t++) begin
         rand_pos(px, py);
         base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(65520, 65535))
                                            : int'($urandom_range(0, 65535));
         w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
         h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
         for (int i = 0; i < w * h; i++) begin
            rom[(base + i) & 32'hFFFF] = ($urandom_range(0, 3) == 0) ? 4'd15
                                                                     : 4'($urandom_range(0, 14));
         end
         do_blit(px, py, base, w, h, $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  blit request; sampled only while ready=1.
REQ-005 pos_x  in  12  signed sprite left column in framebuffer pixels.
REQ-006 pos_y  in  11  signed sprite top row in framebuffer pixels.
REQ-007 spr_base  in  16  sprite ROM address of pixel (row 0, col 0).
REQ-008 spr_w / spr_h  in  8 each  sprite width / height in pixels, 0..255.
REQ-009 ready  out  1  high when idle and able to accept start.
REQ-010 done  out  1  one-cycle pulse on blit completion.
REQ-011 spr_addr  out  16  sprite ROM read address.
REQ-012 spr_data  in  4  palette index from sprite ROM; valid the cycle after spr_addr is presented.
REQ-013 fb_addr  out  19  framebuffer write address, one 4-bit pixel per address.
REQ-014 fb_data  out  4  palette index to write.
REQ-015 fb_we  out  1  framebuffer write enable.

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN, DONE; ready=1 only in IDLE.
REQ-017 On a rising edge with start=1 in IDLE, the block SHALL latch pos_x, pos_y, spr_base, spr_w, spr_h, clear row/col counters, and go to RUN (or to DONE if spr_w=0 or spr_h=0).
REQ-018 In RUN, each cycle SHALL present spr_addr = spr_base + row*spr_w + col (mod 2^16), col incrementing first, row advancing when col = spr_w-1.
REQ-019 After the cycle presenting (row=spr_h-1, col=spr_w-1), RUN SHALL go to DRAIN; DRAIN lasts one cycle, then DONE lasts one cycle with done=1, then IDLE.
REQ-020 Pixel (r,c) read in cycle k SHALL be written in cycle k+1 with fb_data = spr_data and fb_addr = (pos_y+r)*800 + (pos_x+c).
REQ-021 fb_we SHALL be 1 only if spr_data != 15 (transparent), 0 <= pos_x+c <= 799, and 0 <= pos_y+r <= 479.
REQ-022 Clipped and transparent pixels SHALL still consume one RUN cycle; blit duration is independent of position and content.
REQ-023 Coordinate sums SHALL be computed signed at 13 bits to avoid wrap; fb_addr maximum is 383999.
REQ-024 done SHALL be asserted exactly spr_w*spr_h+2 cycles after the accepting edge (1 cycle if either dimension is 0); ready SHALL return high the following cycle.
REQ-025 start while ready=0 SHALL be ignored and not queued.
REQ-026 fb_we SHALL be 0 in IDLE, DONE, and at any time no pixel is pending.

Reset
REQ-027 While rst=1, state SHALL be IDLE immediately (asynchronously): ready=1, done=0, fb_we=0, spr_addr=0, fb_addr=0, fb_data=0, counters and latched operands 0.
REQ-028 Reset during RUN or DRAIN SHALL abort the blit without any further writes and without a done pulse.

Verification
REQ-029 2x2 sprite at (0,0), ROM[0..3]={1,2,15,3} -> writes (addr 0,data 1),(1,2),(801,3); no write for index 15; done 6 cycles after accept.
REQ-030 4x1 sprite at (798,479), all pixels 5 -> exactly two writes, addr 383998 and 383999; done 6 cycles after accept.
REQ-031 2x1 sprite at (-1,0), pixels {7,9} -> single write addr 0 data 9.
REQ-032 spr_w=0, spr_h=10 -> no fb_we, done 1 cycle after accept, ready high next cycle.
REQ-033 8x8 blit with second start pulsed mid-blit -> second start ignored; exactly 64 ROM reads, one done pulse.
REQ-034 rst asserted in RUN cycle 3 of a 4x4 blit -> fb_we 0 in same cycle, ready=1, no done; a fresh 1x1 blit after release completes normally.
